// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver, LSB first, with a valid/ack output
// handshake and one-cycle frame_err / overrun pulses.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | line idle; waits for rx_s low while armed
// START | counting down to the mid-start re-check (glitch filter)
// DATA  | sampling data bits 0..7, one per bit period
// STOP  | counting down to the stop sample, then reports the outcome
module uart_receiver #(
  parameter int CLKS_PER_BIT = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       srst_n,
  input  logic       rx,
  output logic [7:0] out,
  output logic       valid,
  input  logic       ack,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int H     = (CLKS_PER_BIT - 1) / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'((H > 0) ? H - 1 : 0);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   armed;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [2:0]             idx, idx_nxt;
  logic [7:0]             stage;
  logic                   tick;
  logic                   take_bit;
  logic                   stop_sample;

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign busy = (state != IDLE) || (armed && !rx_s);

  // rx synchronizer; resets to the idle (high) level
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) sync_q <= '1;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  // next-state, bit-period down-counter and bit index
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    idx_nxt     = idx;
    take_bit    = 1'b0;
    stop_sample = 1'b0;
    tick        = (cnt == '0);
    case (state)
      IDLE: begin
        if (armed && !rx_s) begin
          idx_nxt = 3'd0;
          // with H=0 the start re-check falls on the detect cycle itself
          if (H == 0) begin
            state_nxt = DATA;
            cnt_nxt   = BIT_LOAD;
          end else begin
            state_nxt = START;
            cnt_nxt   = HALF_LOAD;
          end
        end
      end
      START: begin
        if (tick) begin
          if (rx_s) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = DATA;
            cnt_nxt   = BIT_LOAD;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      DATA: begin
        if (tick) begin
          take_bit = 1'b1;
          cnt_nxt  = BIT_LOAD;
          if (idx == 3'd7) state_nxt = STOP;
          else             idx_nxt   = idx + 3'd1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      STOP: begin
        if (tick) begin
          stop_sample = 1'b1;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state, counter and bit index registers
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  // data bit staging, written by bit index
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n)       stage      <= 8'h00;
    else if (take_bit) stage[idx] <= rx_s;
  end

  // a low stop bit (break/misalignment) disarms until the line is seen high
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n)                    armed <= 1'b0;
    else if (stop_sample && !rx_s)  armed <= 1'b0;
    else if (rx_s)                  armed <= 1'b1;
  end

  // output byte, handshake and status pulses; ack in the completion
  // cycle frees the slot so the new byte loads without an overrun
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      out       <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (stop_sample && rx_s) begin
        if (valid && !ack) begin
          overrun <= 1'b1;
        end else begin
          out   <= stage;
          valid <= 1'b1;
        end
      end else begin
        if (stop_sample) frame_err <= 1'b1;
        if (ack)         valid     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: three instances (CLKS_PER_BIT 1, 4, 8) checked
// every cycle against a schedule-based reference model, plus directed
// literal expectations for the documented scenarios.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       srst_n = 1'b0;
  logic       rx_w   [3];
  logic       ack_w  [3];
  logic [7:0] out_w  [3];
  logic       valid_w[3];
  logic       busy_w [3];
  logic       fe_w   [3];
  logic       ov_w   [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_mode[3];
  bit done = 0;

  // reference model state (values for the current cycle)
  bit         m_s0[3], m_rxs[3], m_armed[3], m_active[3];
  int         m_d[3];
  logic [7:0] m_stage[3], m_out[3];
  bit         m_valid[3], m_fe[3], m_ov[3], m_busy[3];
  int         fe_cnt[3], ov_cnt[3], vcyc[3], busy_cnt[3], last_rise[3];
  logic [7:0] cap0[$];
  int         rise0[$];
  int         cpb_k, h_k, t_k, n_k;
  bit         rxs_k, fe_k, ov_k, v_k, old_v_k;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_receiver #(.CLKS_PER_BIT(1), .SYNC_STAGES(2)) u0 (
    .clk(clk), .srst_n(srst_n), .rx(rx_w[0]), .out(out_w[0]), .valid(valid_w[0]),
    .ack(ack_w[0]), .busy(busy_w[0]), .frame_err(fe_w[0]), .overrun(ov_w[0]));
  uart_receiver #(.CLKS_PER_BIT(4), .SYNC_STAGES(2)) u1 (
    .clk(clk), .srst_n(srst_n), .rx(rx_w[1]), .out(out_w[1]), .valid(valid_w[1]),
    .ack(ack_w[1]), .busy(busy_w[1]), .frame_err(fe_w[1]), .overrun(ov_w[1]));
  uart_receiver #(.CLKS_PER_BIT(8), .SYNC_STAGES(2)) u2 (
    .clk(clk), .srst_n(srst_n), .rx(rx_w[2]), .out(out_w[2]), .valid(valid_w[2]),
    .ack(ack_w[2]), .busy(busy_w[2]), .frame_err(fe_w[2]), .overrun(ov_w[2]));

  function automatic int cpb_of(input int k);
    case (k)
      0:       return 1;
      1:       return 4;
      default: return 8;
    endcase
  endfunction

  // model: rx_s is rx delayed two cycles; samples fall at D+H+n*CPB
  always @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_s0[k] = 1; m_rxs[k] = 1; m_armed[k] = 0; m_active[k] = 0; m_d[k] = 0;
        m_stage[k] = 8'h00; m_out[k] = 8'h00; m_valid[k] = 0;
        m_fe[k] = 0; m_ov[k] = 0; m_busy[k] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        cpb_k = cpb_of(k);
        h_k = (cpb_k - 1) / 2;
        rxs_k = m_rxs[k];
        fe_k = 0; ov_k = 0;
        old_v_k = m_valid[k];
        v_k = m_valid[k] && !ack_w[k];
        if (m_active[k]) begin
          t_k = cyc - m_d[k];
          if (h_k > 0 && t_k == h_k && rxs_k) begin
            m_active[k] = 0;
          end else if (t_k > h_k && (t_k - h_k) % cpb_k == 0) begin
            n_k = (t_k - h_k) / cpb_k;
            if (n_k <= 8) begin
              m_stage[k][n_k-1] = rxs_k;
            end else begin
              m_active[k] = 0;
              if (!rxs_k) fe_k = 1;
              else if (v_k) ov_k = 1;
              else begin
                m_out[k] = m_stage[k];
                v_k = 1;
                if (k == 0) cap0.push_back(m_stage[k]);
              end
            end
          end
        end else if (m_armed[k] && !rxs_k) begin
          m_active[k] = 1;
          m_d[k] = cyc;
        end
        if (fe_k) m_armed[k] = 0;
        else if (rxs_k) m_armed[k] = 1;
        m_valid[k] = v_k; m_fe[k] = fe_k; m_ov[k] = ov_k;
        m_rxs[k] = m_s0[k];
        m_s0[k] = rx_w[k];
        m_busy[k] = m_active[k] || (m_armed[k] && !m_rxs[k]);
        if (fe_k) fe_cnt[k]++;
        if (ov_k) ov_cnt[k]++;
        if (v_k) vcyc[k]++;
        if (m_busy[k]) busy_cnt[k]++;
        if (v_k && !old_v_k) begin
          last_rise[k] = cyc + 1;
          if (k == 0) rise0.push_back(cyc + 1);
        end
      end
    end
  end

  task automatic check(input string name, input int k, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s u%0d cyc=%0d: got %0h expected %0h", name, k, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    while (!done) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        check("out", k, 32'(out_w[k]), 32'(m_out[k]));
        check("valid", k, 32'(valid_w[k]), 32'(m_valid[k]));
        check("busy", k, 32'(busy_w[k]), 32'(m_busy[k]));
        check("frame_err", k, 32'(fe_w[k]), 32'(m_fe[k]));
        check("overrun", k, 32'(ov_w[k]), 32'(m_ov[k]));
      end
    end
  endtask

  // ack policy: 0 never, 1 ack whatever is valid, 2 random, 3 forced high
  task automatic ack_driver();
    forever begin
      @(posedge clk);
      #2;
      for (int k = 0; k < 3; k++) begin
        case (ack_mode[k])
          1:       ack_w[k] = m_valid[k];
          2:       ack_w[k] = 1'($urandom % 2);
          3:       ack_w[k] = 1'b1;
          default: ack_w[k] = 1'b0;
        endcase
      end
    end
  endtask

  task automatic send_frame(input int k, input logic [7:0] b, input bit stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_w[k] = bits[i];
      repeat (cpb_of(k)) step();
    end
  endtask

  task automatic ack_pulse(input int k);
    ack_mode[k] = 3;
    step();
    ack_mode[k] = 0;
  endtask

  task automatic rand_frames(input int k, input int n);
    int gap;
    bit bad;
    for (int f = 0; f < n; f++) begin
      rx_w[k] = 1'b1;
      gap = $urandom_range(0, 3);
      repeat (gap) step();
      if (k != 0 && $urandom % 6 == 0) begin
        rx_w[k] = 1'b0;
        repeat ($urandom_range(1, 1 + (cpb_of(k) - 1) / 2 - 1 + 1) - 1 + 1) step();
        rx_w[k] = 1'b1;
        repeat (2 * cpb_of(k)) step();
      end
      bad = ($urandom % 8 == 0);
      send_frame(k, 8'($urandom), !bad);
      if (bad) begin
        repeat ($urandom_range(0, 5)) step();
        rx_w[k] = 1'b1;
        step();
      end
    end
    rx_w[k] = 1'b1;
  endtask

  int t0, fe0, ov0, v0, b0, c0, r0;

  initial begin
    for (int k = 0; k < 3; k++) begin
      rx_w[k] = 1'b1; ack_w[k] = 1'b0; ack_mode[k] = 0;
      fe_cnt[k] = 0; ov_cnt[k] = 0; vcyc[k] = 0; busy_cnt[k] = 0; last_rise[k] = -1;
    end
    srst_n = 1'b0;
    fork
      monitor();
      ack_driver();
    join_none
    repeat (3) step();
    for (int k = 0; k < 3; k++) begin
      check("rst_out", k, 32'(out_w[k]), 32'h00);
      check("rst_valid", k, 32'(valid_w[k]), 32'h0);
      check("rst_busy", k, 32'(busy_w[k]), 32'h0);
      check("rst_frame_err", k, 32'(fe_w[k]), 32'h0);
      check("rst_overrun", k, 32'(ov_w[k]), 32'h0);
    end
    srst_n = 1'b1;
    repeat (3) step();

    // loopback-style back-to-back A5, 00 with immediate ack
    ack_mode[0] = 1;
    fe0 = fe_cnt[0]; ov0 = ov_cnt[0]; v0 = vcyc[0]; c0 = cap0.size(); r0 = rise0.size();
    t0 = cyc;
    send_frame(0, 8'hA5, 1'b1);
    send_frame(0, 8'h00, 1'b1);
    repeat (6) step();
    check("lb_count", 0, 32'(cap0.size() - c0), 32'd2);
    if (cap0.size() - c0 == 2 && rise0.size() - r0 == 2) begin
      check("lb_byte0", 0, 32'(cap0[c0]), 32'hA5);
      check("lb_byte1", 0, 32'(cap0[c0+1]), 32'h00);
      check("lb_latency0", 0, 32'(rise0[r0]), 32'(t0 + 12));
      check("lb_latency1", 0, 32'(rise0[r0+1]), 32'(t0 + 22));
    end
    check("lb_valid_cycles", 0, 32'(vcyc[0] - v0), 32'd2);
    check("lb_fe", 0, 32'(fe_cnt[0] - fe0), 32'd0);
    check("lb_ov", 0, 32'(ov_cnt[0] - ov0), 32'd0);

    // CLKS_PER_BIT=4, 8'h3C, no ack; held for 100 cycles
    t0 = cyc;
    send_frame(1, 8'h3C, 1'b1);
    check("cpb4_rise", 1, 32'(last_rise[1]), 32'(t0 + 40));
    repeat (100) step();
    check("cpb4_out", 1, 32'(out_w[1]), 32'h3C);
    check("cpb4_model_out", 1, 32'(m_out[1]), 32'h3C);
    check("cpb4_valid", 1, 32'(valid_w[1]), 32'h1);
    ack_pulse(1);
    step();
    check("cpb4_acked", 1, 32'(valid_w[1]), 32'h0);

    // framing error followed by a long break, then a good frame
    fe0 = fe_cnt[0]; v0 = vcyc[0]; c0 = cap0.size();
    send_frame(0, 8'hC3, 1'b0);
    repeat (20) step();
    check("fe_count", 0, 32'(fe_cnt[0] - fe0), 32'd1);
    check("fe_valid_cycles", 0, 32'(vcyc[0] - v0), 32'd0);
    check("fe_busy_after", 0, 32'(busy_w[0]), 32'h0);
    check("fe_model_busy", 0, 32'(m_busy[0]), 32'h0);
    rx_w[0] = 1'b1;
    repeat (3) step();
    send_frame(0, 8'h5A, 1'b1);
    repeat (5) step();
    check("fe_recover_count", 0, 32'(cap0.size() - c0), 32'd1);
    if (cap0.size() > c0) check("fe_recover_byte", 0, 32'(cap0[c0]), 32'h5A);
    check("fe_single_pulse", 0, 32'(fe_cnt[0] - fe0), 32'd1);

    // overrun: 11 then 22 with no ack
    ack_mode[0] = 0;
    ov0 = ov_cnt[0];
    send_frame(0, 8'h11, 1'b1);
    send_frame(0, 8'h22, 1'b1);
    repeat (3) step();
    check("ov_count", 0, 32'(ov_cnt[0] - ov0), 32'd1);
    check("ov_model_out", 0, 32'(m_out[0]), 32'h11);
    check("ov_out", 0, 32'(out_w[0]), 32'h11);
    check("ov_valid", 0, 32'(valid_w[0]), 32'h1);
    ack_pulse(0);
    step();
    check("ov_acked", 0, 32'(valid_w[0]), 32'h0);

    // glitch on CLKS_PER_BIT=8: two low cycles, rejected at D+3
    fe0 = fe_cnt[2]; ov0 = ov_cnt[2]; v0 = vcyc[2]; b0 = busy_cnt[2];
    rx_w[2] = 1'b0;
    repeat (2) step();
    rx_w[2] = 1'b1;
    repeat (20) step();
    check("glitch_busy_cycles", 2, 32'(busy_cnt[2] - b0), 32'd4);
    check("glitch_valid", 2, 32'(vcyc[2] - v0), 32'd0);
    check("glitch_fe", 2, 32'(fe_cnt[2] - fe0), 32'd0);
    check("glitch_ov", 2, 32'(ov_cnt[2] - ov0), 32'd0);

    // reset during data bit 4 of 8'hFF
    ack_mode[0] = 1;
    rx_w[0] = 1'b0;
    step();
    rx_w[0] = 1'b1;
    repeat (6) step();
    check("mid_busy", 0, 32'(busy_w[0]), 32'h1);
    check("mid_out_before", 0, 32'(out_w[0]), 32'h11);
    srst_n = 1'b0;
    #1;
    check("mid_rst_out", 0, 32'(out_w[0]), 32'h00);
    check("mid_rst_valid", 0, 32'(valid_w[0]), 32'h0);
    check("mid_rst_busy", 0, 32'(busy_w[0]), 32'h0);
    check("mid_rst_fe", 0, 32'(fe_w[0]), 32'h0);
    check("mid_rst_ov", 0, 32'(ov_w[0]), 32'h0);
    repeat (2) step();
    srst_n = 1'b1;
    repeat (3) step();
    c0 = cap0.size();
    send_frame(0, 8'h81, 1'b1);
    repeat (5) step();
    check("mid_next_count", 0, 32'(cap0.size() - c0), 32'd1);
    if (cap0.size() > c0) check("mid_next_byte", 0, 32'(cap0[c0]), 32'h81);

    // randomized traffic with random ack on all instances
    for (int k = 0; k < 3; k++) ack_mode[k] = 2;
    fork
      rand_frames(0, 40);
      rand_frames(1, 8);
      rand_frames(2, 6);
    join
    repeat (20) step();

    done = 1;
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
